iomem_uart: RTL



---
 rtl/iomem_uart_pkg.sv | 29 ++
 rtl/iomem_uart_if.sv | 15 +
 rtl/iomem_uart_rx.sv | 103 ++++++++++
 rtl/iomem_uart.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/iomem_uart_pkg.sv
// iomem_uart_pkg
// Shared definitions for the memory-mapped UART: register offsets (word
// index taken from addr[3:2]), STATUS bit positions, TX/RX state encodings
// and the minimum usable bit period.
package iomem_uart_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIV    = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  localparam int ST_TX_FULL   = 0;
  localparam int ST_TX_EMPTY  = 1;
  localparam int ST_TX_BUSY   = 2;
  localparam int ST_RX_VALID  = 3;
  localparam int ST_OVERRUN   = 4;
  localparam int ST_FRAME_ERR = 5;

  localparam logic [15:0] MIN_DIV = 16'd4;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  // Bit periods below MIN_DIV are kept in the register but clamped when used.
  function automatic logic [15:0] eff_div(input logic [15:0] d);
    return (d < MIN_DIV) ? MIN_DIV : d;
  endfunction

endpackage

// File: rtl/iomem_uart_if.sv
// iomem_uart_if
// SoC iomem request/response bundle.
//   valid/addr/wdata/wstrb : driven by the initiator (master)
//   ready/rdata            : driven by the responder (slave)
interface iomem_uart_if;
  logic        valid;
  logic        ready;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [31:0] rdata;

  modport master (output valid, addr, wdata, wstrb, input ready, rdata);
  modport slave  (input valid, addr, wdata, wstrb, output ready, rdata);
endinterface

// File: rtl/iomem_uart_rx.sv
// iomem_uart_rx
// 8N1 receiver: two-flop synchroniser, falling-edge start detection,
// mid-bit sampling.
//   clk, rst   : system clock, synchronous active-high reset
//   rx         : asynchronous serial input
//   bit_len    : clocks per bit (already clamped by the caller)
//   byte_done  : one-cycle pulse, byte_data holds a good frame's byte
//   byte_data  : last received byte
//   frame_err  : one-cycle pulse when the stop bit samples low
module iomem_uart_rx
  import iomem_uart_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  input  logic [15:0] bit_len,
  output logic        byte_done,
  output logic [7:0]  byte_data,
  output logic        frame_err
);

  logic        sync1, sync2, sync_d;
  rx_state_t   state;
  logic [15:0] cnt;
  logic [2:0]  idx;
  logic [7:0]  sh;

  // Synchroniser; sync_d keeps the previous synchronised level for edge detect.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      sync_d <= 1'b1;
    end else begin
      sync1  <= rx;
      sync2  <= sync1;
      sync_d <= sync2;
    end
  end

  // Receive FSM. The start bit is re-checked half a bit after the edge so
  // every later sample lands mid-bit; a high re-check is treated as a glitch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RX_IDLE;
      cnt       <= '0;
      idx       <= '0;
      sh        <= '0;
      byte_done <= 1'b0;
      byte_data <= '0;
      frame_err <= 1'b0;
    end else begin
      byte_done <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        RX_IDLE: begin
          if (sync_d && !sync2) begin
            cnt   <= (bit_len >> 1) - 16'd1;
            state <= RX_START;
          end
        end
        RX_START: begin
          if (cnt == '0) begin
            if (sync2) begin
              state <= RX_IDLE;
            end else begin
              cnt   <= bit_len - 16'd1;
              idx   <= '0;
              state <= RX_DATA;
            end
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        RX_DATA: begin
          if (cnt == '0) begin
            sh  <= {sync2, sh[7:1]};
            cnt <= bit_len - 16'd1;
            idx <= idx + 3'd1;
            if (idx == 3'd7) state <= RX_STOP;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        RX_STOP: begin
          if (cnt == '0) begin
            if (sync2) begin
              byte_done <= 1'b1;
              byte_data <= sh;
            end else begin
              frame_err <= 1'b1;
            end
            state <= RX_IDLE;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/iomem_uart.sv
// iomem_uart
// Memory-mapped 8N1 UART responder on the iomem bus.
//   clk, rst : system clock, synchronous active-high reset
//   bus      : iomem slave port (valid/addr/wdata/wstrb in, ready/rdata out)
//   uart_tx  : serial output, idle high
//   uart_rx  : asynchronous serial input
// Registers: DATA (0x0), STATUS (0x4), DIV (0x8), reserved (0xC).
module iomem_uart
  import iomem_uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0300_0000,
  parameter logic [15:0] DEFAULT_DIV = 16'd104
) (
  input  logic         clk,
  input  logic         rst,
  iomem_uart_if.slave  bus,
  output logic         uart_tx,
  input  logic         uart_rx
);

  logic        sel, is_write, data_push_req, ack, push, read_clear, stat_clr;
  logic [1:0]  reg_sel;
  logic [31:0] read_value;

  logic [7:0]  fifo [4];
  logic [1:0]  wr_ptr, rd_ptr;
  logic [2:0]  count;
  logic        tx_full, tx_empty, tx_pop;

  logic [15:0] div_reg, div_eff;

  tx_state_t   tx_state;
  logic [15:0] tx_cnt;
  logic [2:0]  tx_idx;
  logic [7:0]  tx_sh;

  logic        rx_done, rx_ferr;
  logic [7:0]  rx_data, rx_byte;
  logic        rx_valid, rx_overrun, rx_frame_err;

  logic        unused_bus;
  assign unused_bus = ^{bus.addr[1:0], bus.wdata[31:16], bus.wstrb[3:2]};

  assign tx_full  = (count == 3'd4);
  assign tx_empty = (count == 3'd0);
  assign div_eff  = eff_div(div_reg);

  // Request decode. A DATA push into a full FIFO is held off (no ack) until
  // a slot frees; ready is never acked twice in a row.
  always_comb begin
    sel           = bus.valid && (bus.addr[31:4] == BASE_ADDR[31:4]);
    reg_sel       = bus.addr[3:2];
    is_write      = |bus.wstrb;
    data_push_req = (reg_sel == REG_DATA) && bus.wstrb[0];
    ack           = sel && !bus.ready && !(data_push_req && tx_full);
    push          = ack && data_push_req;
    read_clear    = ack && !is_write && (reg_sel == REG_DATA);
    stat_clr      = ack && (reg_sel == REG_STATUS) && bus.wstrb[0];
    tx_pop        = !tx_empty && ((tx_state == TX_IDLE) ||
                                  (tx_state == TX_STOP && tx_cnt == '0));
  end

  // Read data mux.
  always_comb begin
    read_value = '0;
    case (reg_sel)
      REG_DATA:   read_value = rx_valid ? {24'h0, rx_byte} : 32'hFFFF_FFFF;
      REG_STATUS: begin
        read_value[ST_TX_FULL]   = tx_full;
        read_value[ST_TX_EMPTY]  = tx_empty;
        read_value[ST_TX_BUSY]   = (tx_state != TX_IDLE);
        read_value[ST_RX_VALID]  = rx_valid;
        read_value[ST_OVERRUN]   = rx_overrun;
        read_value[ST_FRAME_ERR] = rx_frame_err;
      end
      REG_DIV:    read_value = {16'h0, div_reg};
      default:    read_value = '0;
    endcase
  end

  // Registered response: ready and rdata for exactly one cycle per request.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.ready <= 1'b0;
      bus.rdata <= '0;
    end else begin
      bus.ready <= ack;
      bus.rdata <= (ack && !is_write) ? read_value : 32'h0;
    end
  end

  // DIV register, byte-strobed.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_reg <= DEFAULT_DIV;
    end else if (ack && reg_sel == REG_DIV) begin
      if (bus.wstrb[0]) div_reg[7:0]  <= bus.wdata[7:0];
      if (bus.wstrb[1]) div_reg[15:8] <= bus.wdata[15:8];
    end
  end

  // RX flags. Clears come first so a set in the same cycle wins; a byte
  // arriving while the old one is being read out is not an overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_byte      <= '0;
      rx_valid     <= 1'b0;
      rx_overrun   <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      if (stat_clr && bus.wdata[ST_OVERRUN])   rx_overrun   <= 1'b0;
      if (stat_clr && bus.wdata[ST_FRAME_ERR]) rx_frame_err <= 1'b0;
      if (rx_done) begin
        rx_byte  <= rx_data;
        rx_valid <= 1'b1;
        if (rx_valid && !read_clear) rx_overrun <= 1'b1;
      end else if (read_clear) begin
        rx_valid <= 1'b0;
      end
      if (rx_ferr) rx_frame_err <= 1'b1;
    end
  end

  // TX FIFO storage (no reset needed, validity is tracked by count).
  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= bus.wdata[7:0];
  end

  // TX FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 2'd1;
      if (tx_pop) rd_ptr <= rd_ptr + 2'd1;
      case ({push, tx_pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  // TX shifter. The period counter reloads from DIV at each bit boundary,
  // so a DIV change lands on the next bit. STOP chains straight into START
  // when another byte is waiting.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_sh    <= '0;
      uart_tx  <= 1'b1;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          uart_tx <= 1'b1;
          if (tx_pop) begin
            tx_sh    <= fifo[rd_ptr];
            tx_cnt   <= div_eff - 16'd1;
            uart_tx  <= 1'b0;
            tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (tx_cnt == '0) begin
            tx_cnt   <= div_eff - 16'd1;
            uart_tx  <= tx_sh[0];
            tx_sh    <= {1'b0, tx_sh[7:1]};
            tx_idx   <= '0;
            tx_state <= TX_DATA;
          end else begin
            tx_cnt <= tx_cnt - 16'd1;
          end
        end
        TX_DATA: begin
          if (tx_cnt == '0) begin
            tx_cnt <= div_eff - 16'd1;
            if (tx_idx == 3'd7) begin
              uart_tx  <= 1'b1;
              tx_state <= TX_STOP;
            end else begin
              uart_tx <= tx_sh[0];
              tx_sh   <= {1'b0, tx_sh[7:1]};
              tx_idx  <= tx_idx + 3'd1;
            end
          end else begin
            tx_cnt <= tx_cnt - 16'd1;
          end
        end
        TX_STOP: begin
          if (tx_cnt == '0) begin
            if (tx_pop) begin
              tx_sh    <= fifo[rd_ptr];
              tx_cnt   <= div_eff - 16'd1;
              uart_tx  <= 1'b0;
              tx_state <= TX_START;
            end else begin
              uart_tx  <= 1'b1;
              tx_state <= TX_IDLE;
            end
          end else begin
            tx_cnt <= tx_cnt - 16'd1;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  iomem_uart_rx u_rx (
    .clk       (clk),
    .rst       (rst),
    .rx        (uart_rx),
    .bit_len   (div_eff),
    .byte_done (rx_done),
    .byte_data (rx_data),
    .frame_err (rx_ferr)
  );

endmodule
